// File: rtl/motor_sched_pkg.sv
// Shared types and defaults for the motor ramp scheduler.
// Optional watchdog is enabled with MOTOR_WATCHDOG_EN.
package motor_sched_pkg;

  localparam int DUTY_W_DEF = 10;
  localparam int STEP_DEF   = 8;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  typedef struct packed {
    logic                  dir;
    logic [DUTY_W_DEF-1:0] duty;
  } motor_target_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_ramp_step.sv
// One-motor ramp decision: moves duty toward target by at most STEP,
// passing through zero before a direction change.
module motor_ramp_step
  import motor_sched_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic [DUTY_W-1:0] cur_duty_i,
  input  logic              cur_dir_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic              tgt_dir_i,
  output logic [DUTY_W-1:0] next_duty_o,
  output logic              next_dir_o
);

  localparam logic [DUTY_W:0] STEP_W = (DUTY_W+1)'(STEP);

  logic [DUTY_W:0] cur_w;
  logic [DUTY_W:0] tgt_w;
  logic [DUTY_W:0] diff_w;
  logic [DUTY_W:0] res_w;
  logic            rev;

  always_comb begin
    cur_w      = {1'b0, cur_duty_i};
    tgt_w      = {1'b0, tgt_duty_i};
    rev        = cur_dir_i != tgt_dir_i;
    diff_w     = '0;
    res_w      = cur_w;
    next_dir_o = cur_dir_i;
    unique case (1'b1)
      rev && (cur_w != '0): begin
        res_w = (cur_w > STEP_W) ? cur_w - STEP_W : '0;
      end
      rev && (cur_w == '0): begin
        next_dir_o = tgt_dir_i;
      end
      !rev && (tgt_w > cur_w): begin
        diff_w = tgt_w - cur_w;
        res_w  = cur_w + ((diff_w > STEP_W) ? STEP_W : diff_w);
      end
      !rev && (tgt_w < cur_w): begin
        diff_w = cur_w - tgt_w;
        res_w  = cur_w - ((diff_w > STEP_W) ? STEP_W : diff_w);
      end
      default: ;
    endcase
    next_duty_o = DUTY_W'(res_w);
  end

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Command front-end and tick-driven ramp sequencer for NUM_MOTORS channels.
// Define MOTOR_WATCHDOG_EN to add the command-loss watchdog.
module motor_ramp_scheduler
  import motor_sched_pkg::*;
#(
  parameter int NUM_MOTORS = 4,
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int TICK_DIV   = 50000
`ifdef MOTOR_WATCHDOG_EN
  ,
  parameter int WDOG_TICKS = 500
`endif
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [idx_w(NUM_MOTORS)-1:0] cmd_motor,
  input  logic                         cmd_dir,
  input  logic [DUTY_W-1:0]            cmd_duty,
  output logic [NUM_MOTORS*DUTY_W-1:0] duty_out,
  output logic [NUM_MOTORS-1:0]        dir_out,
  output logic                         busy,
  output logic                         wdog_trip
);

  localparam int MW = idx_w(NUM_MOTORS);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);
  localparam logic [MW-1:0] IDX_LAST = MW'(NUM_MOTORS - 1);
  localparam logic [MW:0] NM = (MW+1)'(NUM_MOTORS);

  state_t state_q;
  logic [MW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic pend_q;
  logic wrap;
  logic accept;

  logic [NUM_MOTORS-1:0][DUTY_W-1:0] duty_q;
  logic [NUM_MOTORS-1:0] dir_q;
  logic [NUM_MOTORS-1:0][DUTY_W-1:0] tgt_duty_q;
  logic [NUM_MOTORS-1:0] tgt_dir_q;

  logic [DUTY_W-1:0] nxt_duty_d;
  logic nxt_dir_d;

  assign wrap = cnt_q == CNT_TOP;
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
  assign cmd_ready = !reset && (state_q == IDLE) && !pend_q;
  assign busy = !reset && (state_q == SWEEP);
  assign accept = cmd_ready && cmd_valid;
  assign duty_out = duty_q;
  assign dir_out = dir_q;

  motor_ramp_step #(
    .DUTY_W(DUTY_W),
    .STEP  (STEP)
  ) u_step (
    .cur_duty_i (duty_q[idx_q]),
    .cur_dir_i  (dir_q[idx_q]),
    .tgt_duty_i (tgt_duty_q[idx_q]),
    .tgt_dir_i  (tgt_dir_q[idx_q]),
    .next_duty_o(nxt_duty_d),
    .next_dir_o (nxt_dir_d)
  );

`ifdef MOTOR_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(WDOG_TICKS);
  logic [WW-1:0] wdog_q;
  logic trip_q;
  assign wdog_trip = trip_q && !reset;
`else
  assign wdog_trip = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      duty_q     <= '0;
      dir_q      <= '0;
      tgt_duty_q <= '0;
      tgt_dir_q  <= '0;
`ifdef MOTOR_WATCHDOG_EN
      wdog_q     <= '0;
      trip_q     <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            pend_q  <= 1'b0;
          end else if (accept && ({1'b0, cmd_motor} < NM)) begin
            tgt_duty_q[cmd_motor] <= cmd_duty;
            tgt_dir_q[cmd_motor]  <= cmd_dir;
          end
        end
        SWEEP: begin
          duty_q[idx_q] <= nxt_duty_d;
          dir_q[idx_q]  <= nxt_dir_d;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (wrap) pend_q <= 1'b1;
`ifdef MOTOR_WATCHDOG_EN
      // An accepted command beats a trip landing in the same cycle.
      if (accept) begin
        wdog_q <= '0;
        trip_q <= 1'b0;
      end else if (wrap && (wdog_q != WD_MAX)) begin
        wdog_q <= wdog_q + 1'b1;
        if (wdog_q == WD_MAX - 1'b1) begin
          trip_q     <= 1'b1;
          tgt_duty_q <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// Directed scoreboard bench for motor_ramp_scheduler (TICK_DIV=8).
// Build with MOTOR_WATCHDOG_EN to exercise the watchdog path instead.
module tb_motor_ramp_scheduler;
  import motor_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int TD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cv, cr, cd, busy, wt;
  logic [1:0] cm;
  logic [DW-1:0] cdu;
  logic [N*DW-1:0] dout;
  logic [N-1:0] dirv;

  logic cv2, cr2, cd2, busy2, wt2;
  logic [1:0] cm2;
  logic [DW-1:0] cdu2;
  logic [3*DW-1:0] dout2;
  logic [2:0] dirv2;

  motor_ramp_scheduler #(
    .NUM_MOTORS(N), .DUTY_W(DW), .STEP(8), .TICK_DIV(TD)
`ifdef MOTOR_WATCHDOG_EN
    , .WDOG_TICKS(4)
`endif
  ) dut (
    .CLOCK_50(clk), .reset(rst), .cmd_valid(cv), .cmd_ready(cr),
    .cmd_motor(cm), .cmd_dir(cd), .cmd_duty(cdu), .duty_out(dout),
    .dir_out(dirv), .busy(busy), .wdog_trip(wt)
  );

  motor_ramp_scheduler #(
    .NUM_MOTORS(3), .DUTY_W(DW), .STEP(8), .TICK_DIV(TD)
`ifdef MOTOR_WATCHDOG_EN
    , .WDOG_TICKS(4)
`endif
  ) dut3 (
    .CLOCK_50(clk), .reset(rst), .cmd_valid(cv2), .cmd_ready(cr2),
    .cmd_motor(cm2), .cmd_dir(cd2), .cmd_duty(cdu2), .duty_out(dout2),
    .dir_out(dirv2), .busy(busy2), .wdog_trip(wt2)
  );

  typedef struct {
    int            m;
    motor_target_t t;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int m, input bit d, input int du,
                               input string tag);
    exp_t e;
    e.m = m;
    e.t.dir = d;
    e.t.duty = DW'(du);
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic send(input int m, input bit d, input int du,
                      input string tag);
    int k = 0;
    cv = 1'b1;
    cm = m[1:0];
    cd = d;
    cdu = DW'(du);
    while (!cr && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rdy"}, 64'(cr), 64'(1));
    @(negedge clk);
    cv = 1'b0;
  endtask

  task automatic sweep_wait(input string tag);
    int k = 0;
    while (!busy && k < 4 * TD) begin
      @(negedge clk);
      k++;
    end
    while (busy && k < 4 * TD) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_sweep_seen"}, 64'(k < 4 * TD), 64'(1));
  endtask

  task automatic tick_check();
    exp_t e;
    e = sb.pop_front();
    sweep_wait(e.tag);
    chk({e.tag, "_duty"}, 64'(dout[e.m*DW +: DW]), 64'(e.t.duty));
    chk({e.tag, "_dir"}, 64'(dirv[e.m]), 64'(e.t.dir));
  endtask

  task automatic drain();
    while (sb.size() > 0) tick_check();
  endtask

  initial begin
    rst = 1'b1;
    cv = 1'b0; cm = '0; cd = 1'b0; cdu = '0;
    cv2 = 1'b0; cm2 = '0; cd2 = 1'b0; cdu2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_duty", 64'(dout), 64'(0));
    chk("rst_dir", 64'(dirv), 64'(0));
    chk("rst_rdy", 64'(cr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wdog", 64'(wt), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rdy", 64'(cr), 64'(1));
    chk("post_busy", 64'(busy), 64'(0));
    @(negedge clk);

`ifdef MOTOR_WATCHDOG_EN
    send(0, 0, 16, "wd_set");
    push(0, 0, 8, "wd1");
    push(0, 0, 16, "wd2");
    push(0, 0, 16, "wd3");
    drain();
    chk("wd_pre", 64'(wt), 64'(0));
    push(0, 0, 8, "wd4");
    drain();
    chk("wd_trip", 64'(wt), 64'(1));
    push(0, 0, 0, "wd5");
    drain();
    send(0, 0, 0, "wd_clr");
    chk("wd_clr", 64'(wt), 64'(0));
`else
    // Ramp up from zero.
    send(1, 0, 20, "up");
    push(1, 0, 8, "up1");
    push(1, 0, 16, "up2");
    push(1, 0, 20, "up3");
    push(1, 0, 20, "up_hold");
    drain();
    chk("up_bus", 64'(dout), 64'(20) << DW);
    chk("up_dirs", 64'(dirv), 64'(0));

    // Reversal passes through zero.
    send(1, 1, 10, "rev");
    push(1, 0, 12, "rev1");
    push(1, 0, 4, "rev2");
    push(1, 0, 0, "rev3");
    push(1, 1, 0, "rev_flip");
    push(1, 1, 8, "rev4");
    push(1, 1, 10, "rev5");
    drain();

    // Command raised in the cycle the tick becomes pending.
    repeat (3) @(negedge clk);
    cv = 1'b1; cm = 2'd2; cd = 1'b0; cdu = DW'(5);
    chk("blk_rdy0", 64'(cr), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blk_busy", 64'(busy), 64'(1));
      chk("blk_rdy", 64'(cr), 64'(0));
    end
    @(negedge clk);
    chk("blk_idle", 64'(busy), 64'(0));
    chk("blk_rdy1", 64'(cr), 64'(1));
    @(negedge clk);
    cv = 1'b0;
    push(2, 0, 5, "blk");
    drain();
    chk("blk_bus", 64'(dout), (64'(5) << (2 * DW)) | (64'(10) << DW));
    chk("blk_dirs", 64'(dirv), 64'(4'b0010));

    // Last of back-to-back commands wins.
    send(0, 0, 100, "b2b_a");
    send(0, 0, 3, "b2b_b");
    push(0, 0, 3, "b2b");
    drain();

    // Long ramp, then saturate at full scale.
    send(3, 0, 1020, "sat_a");
    for (int k = 1; k <= 128; k++)
      push(3, 0, (8 * k > 1020) ? 1020 : 8 * k, "sat_ramp");
    drain();
    send(3, 0, 1023, "sat_b");
    push(3, 0, 1023, "sat");
    push(3, 0, 1023, "sat_hold");
    drain();

    // Out-of-range channel on the 3-motor build.
    cv2 = 1'b1; cm2 = 2'd3; cd2 = 1'b1; cdu2 = DW'(100);
    for (int k = 0; k < 40 && !cr2; k++) @(negedge clk);
    chk("oor_rdy", 64'(cr2), 64'(1));
    @(negedge clk);
    cv2 = 1'b0;
    repeat (3 * TD) @(negedge clk);
    chk("oor_duty", 64'(dout2), 64'(0));
    chk("oor_dir", 64'(dirv2), 64'(0));

    // Reset in the middle of a sweep.
    send(0, 0, 500, "mid");
    for (int k = 0; k < 4 * TD && !busy; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_duty", 64'(dout), 64'(0));
    chk("mid_dir", 64'(dirv), 64'(0));
    chk("mid_rdy", 64'(cr), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * TD) @(negedge clk);
    chk("mid_after", 64'(dout), 64'(0));
    chk("wdog_off", 64'(wt), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
